// File: rtl/arb_mux_n.sv
// N-input, W-bit registered multiplexer with a valid/ready handshake.
// Picks one source per cycle, either by external select (MODE 0) or round-robin (MODE 1).
module arb_mux_n #(
   parameter int N    = 4,
   parameter int W    = 32,
   parameter int SELW = 2,
   parameter int MODE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N*W-1:0]   in_data,
   input  logic [N-1:0]     in_valid,
   output logic [N-1:0]     in_ready,
   input  logic [SELW-1:0]  sel,
   output logic [W-1:0]     out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SELW-1:0]  out_src
);

   logic            gnt_vld;
   logic [SELW-1:0] gnt_idx;
   logic [W-1:0]    gnt_data;
   logic            can_acc;
   logic            xfer;

   logic [W-1:0]    data_q, data_d;
   logic [SELW-1:0] src_q,  src_d;
   logic [SELW-1:0] rr_q,   rr_d;
   logic            valid_q, valid_d;

   // The grant search runs from a fixed start (sel or rr_q), so the first hit wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      if (MODE == 0) begin
         for (int i = 0; i < N; i++) begin
            if (!gnt_vld && sel == SELW'(i) && in_valid[i]) begin
               gnt_vld = 1'b1;
               gnt_idx = SELW'(i);
            end
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            if (!gnt_vld && in_valid[(int'(rr_q) + k) % N]) begin
               gnt_vld = 1'b1;
               gnt_idx = SELW'((int'(rr_q) + k) % N);
            end
         end
      end
   end

   always_comb begin
      gnt_data = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_idx == SELW'(i)) gnt_data = in_data[i*W +: W];
      end
   end

   assign can_acc = !valid_q || out_ready;
   assign xfer    = gnt_vld && can_acc;

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         in_ready[i] = xfer && (gnt_idx == SELW'(i));
      end
   end

   // NOTE: next state is built with blocking assignments in always_comb, starting from
   // a full default so no path leaves a variable unassigned (which would infer a latch).
   always_comb begin
      data_d  = data_q;
      src_d   = src_q;
      valid_d = valid_q;
      rr_d    = rr_q;
      if (xfer) begin
         data_d  = gnt_data;
         src_d   = gnt_idx;
         valid_d = 1'b1;
         if (MODE != 0) begin
            rr_d = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
         end
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments; the output data register is
   // reset too, since a zeroed out_data is part of the visible reset state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         src_q   <= '0;
         valid_q <= 1'b0;
         rr_q    <= '0;
      end else begin
         data_q  <= data_d;
         src_q   <= src_d;
         valid_q <= valid_d;
         rr_q    <= rr_d;
      end
   end

   assign out_data  = data_q;
   assign out_src   = src_q;
   assign out_valid = valid_q;

endmodule
